rvh_pmp_csr_ctrl: RTL

CSR-side controller that drives the PMP block's configuration interface: cfg/addr set and origin-payload readback. It accepts one CSR access at a time from the CSR unit (pmpcfg*/pmpaddr*, csrrw/csrrs/csrrc/read). For each access it reads the current value, applies the read-modify-write op and WARL legalisation, pulses the set strobe, and returns the old value. It sits between the CSR file and the PMP checker and is the writer/reader peer of the PMP set/origin interface.

---
 rtl/rvh_pmp_csr_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/rvh_pmp_csr_ctrl.sv
// CSR-side controller for the PMP configuration interface: reads the current
// pmpcfg/pmpaddr value, applies csrrw/csrrs/csrrc with WARL legalisation, strobes the write, returns the old value.
module rvh_pmp_csr_ctrl #(
  parameter int PMP_ENTRY_COUNT    = 64,
  parameter int PMPCFG_ENTRY_COUNT = 8,
  parameter int PADDR_WIDTH        = 56,
  parameter int PMPADDR_ID_WIDTH   = $clog2(PMP_ENTRY_COUNT),
  parameter int PMPCFG_ID_WIDTH    = $clog2(PMPCFG_ENTRY_COUNT)
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [1:0]                  priv_lvl_i,
  input  logic                        csr_req_vld_i,
  output logic                        csr_req_rdy_o,
  input  logic [11:0]                 csr_req_addr_i,
  input  logic [1:0]                  csr_req_op_i,
  input  logic [63:0]                 csr_req_wdata_i,
  output logic                        csr_resp_vld_o,
  input  logic                        csr_resp_rdy_i,
  output logic [63:0]                 csr_resp_rdata_o,
  output logic                        csr_resp_illegal_o,
  output logic                        cfg_set_vld_o,
  output logic [PMPCFG_ID_WIDTH-1:0]  cfg_set_addr_o,
  output logic [63:0]                 cfg_set_payload_o,
  input  logic [63:0]                 cfg_origin_payload_i,
  output logic                        addr_set_vld_o,
  output logic [PMPADDR_ID_WIDTH-1:0] addr_set_addr_o,
  output logic [63:0]                 addr_set_payload_o,
  input  logic [63:0]                 addr_origin_payload_i
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

  localparam logic [3:0]  CFG_CNT   = 4'(PMPCFG_ENTRY_COUNT);
  localparam logic [7:0]  PA_CNT    = 8'(PMP_ENTRY_COUNT);
  localparam logic [63:0] ADDR_MASK = (64'd1 << (PADDR_WIDTH - 2)) - 64'd1;

  state_e      state_q, state_d;
  logic [11:0] addr_q, addr_d;
  logic [1:0]  op_q, op_d;
  logic [63:0] wdata_q, wdata_d;
  logic [1:0]  priv_q, priv_d;
  logic [63:0] rdata_q, rdata_d;

  logic [3:0]  cfg_off;
  logic [7:0]  pa_off;
  logic        cfg_ok, pa_ok, illegal;
  logic [63:0] new_val, cfg_warl, addr_warl;

  // pmpcfg base 0x3A0 is 16-aligned, so the low nibble is the offset directly.
  assign cfg_off = addr_q[3:0];
  assign pa_off  = addr_q[7:0] - 8'hB0;
  assign cfg_ok  = (addr_q >= 12'h3A0) && (addr_q <= 12'h3AF) && !cfg_off[0]
                   && ({1'b0, cfg_off[3:1]} < CFG_CNT);
  assign pa_ok   = (addr_q >= 12'h3B0) && (addr_q <= 12'h3EF) && (pa_off < PA_CNT);
  assign illegal = (priv_q != 2'd3) || !(cfg_ok || pa_ok);

  always_comb begin
    new_val = rdata_q;
    case (op_q)
      2'd1:    new_val = wdata_q;
      2'd2:    new_val = rdata_q | wdata_q;
      2'd3:    new_val = rdata_q & ~wdata_q;
      default: new_val = rdata_q;
    endcase
  end

  // Per-byte cfg legalisation: reserved bits 6:5 cleared, R=0/W=1 collapses to W=0.
  for (genvar gi = 0; gi < 8; gi++) begin : g_cfg_warl
    logic [7:0] b;
    assign b = new_val[8*gi +: 8];
    assign cfg_warl[8*gi +: 8] = {b[7], 2'b00, b[4:2], b[1] & b[0], b[0]};
  end
  assign addr_warl = new_val & ADDR_MASK;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      op_q    <= '0;
      wdata_q <= '0;
      priv_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
      priv_q  <= priv_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    op_d    = op_q;
    wdata_d = wdata_q;
    priv_d  = priv_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (csr_req_vld_i) begin
        addr_d  = csr_req_addr_i;
        op_d    = csr_req_op_i;
        wdata_d = csr_req_wdata_i;
        priv_d  = priv_lvl_i;
        state_d = READ;
      end
      READ: begin
        rdata_d = illegal ? 64'd0 : (cfg_ok ? cfg_origin_payload_i : addr_origin_payload_i);
        state_d = (!illegal && op_q != 2'd0) ? WRITE : RESP;
      end
      WRITE: state_d = RESP;
      RESP: if (csr_resp_rdy_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    csr_req_rdy_o      = (state_q == IDLE);
    csr_resp_vld_o     = (state_q == RESP);
    csr_resp_rdata_o   = (state_q == RESP) ? rdata_q : 64'd0;
    csr_resp_illegal_o = (state_q == RESP) && illegal;
    cfg_set_addr_o     = '0;
    addr_set_addr_o    = '0;
    if (state_q != IDLE) begin
      if (cfg_ok) cfg_set_addr_o = cfg_off[PMPCFG_ID_WIDTH:1];
      if (pa_ok)  addr_set_addr_o = pa_off[PMPADDR_ID_WIDTH-1:0];
    end
    cfg_set_vld_o      = (state_q == WRITE) && cfg_ok;
    addr_set_vld_o     = (state_q == WRITE) && pa_ok;
    cfg_set_payload_o  = cfg_set_vld_o  ? cfg_warl  : 64'd0;
    addr_set_payload_o = addr_set_vld_o ? addr_warl : 64'd0;
  end

endmodule
